mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Arbitrates the single read/write port (port A) of the Chip-8 4 KiB CPU memory between three requesters: the ROM loader (`ld`), the CPU core (`cpu`, opcode fetch and Fx55/Fx65/Fx33 data access) and the sprite draw unit (`spr`, reads at I..I+n).
- One access is issued per cycle.
- Read data returns one cycle after grant, matching the memory's registered output.
- Locked bursts are supported and bounded by a watchdog.
- Port B (display scan) is not touched.

## Interface
- `ADDR_W`, 12, memory address width.
- `DATA_W`, 8, memory data width.
- `LOCK_MAX`, 16, maximum consecutive cycles one requester may hold a lock; range 2..255.
- `clk  in  1  system clock; all logic on rising edge`
- `rst_n  in  1  asynchronous active-low reset`
- `<r>_req  in  1  access request, r ∈ {ld, cpu, spr}`
- `<r>_lock  in  1  keep ownership after this access (burst); ignored for ld`
- `<r>_write  in  1  1 = write, 0 = read`
- `<r>_addr  in  ADDR_W  access address`
- `<r>_wdata  in  DATA_W  write data`
- `<r>_gnt  out  1  access accepted this cycle (combinational)`
- `<r>_rvalid  out  1  rdata valid for this requester's read granted last cycle`
- `rdata  out  DATA_W  shared read data, equal to mem_rdata`
- `mem_en  out  1  memory port enable`
- `mem_write  out  1  memory write strobe`
- `mem_addr  out  ADDR_W  memory address`
- `mem_wdata  out  DATA_W  memory write data`
- `mem_rdata  in  DATA_W  memory registered read data`
- `wp_err  out  1  registered pulse: a granted write targeted addr < 0x200`

## Operation
- States: `OPEN` (normal arbitration) and `LOCKED(owner)` (owner ∈ {cpu, spr}).
- Priority in `OPEN`:
  - `ld` has absolute priority whenever `ld_req`=1.
  - Otherwise `cpu` and `spr` share round-robin. A `last` pointer marks the requester that was granted most recently. When both request, the one not equal to `last` wins. `last` resets to spr, so cpu wins first.
- At most one `*_gnt` is high per cycle. When `gnt` is high, mem_en=1 and mem_write/addr/wdata mux from the winner. With no grant, mem_en=0, mem_write=0, and addr/wdata are don't-care.
- Entering a lock: cpu/spr granted with `lock`=1 in `OPEN` → `LOCKED(owner)` next cycle, lock counter loaded to 1.
- Behaviour in `LOCKED(owner)`:
  - Only the owner can be granted, and only when owner `req`=1.
  - The other requester and ld are blocked, even if ld requests.
  - A cycle with owner req=0 and lock=1 issues nothing but keeps ownership.
- Leaving a lock:
  - Owner lock=0 in any cycle → `OPEN` next cycle. An access requested in that same cycle is still granted.
  - Lock counter reaches `LOCK_MAX` → forced `OPEN` next cycle. The owner is treated as `last`, so the other requester wins if pending. The owner may relock on a later grant.
- Read return: `<r>_rvalid` = registered (`<r>_gnt` & !`<r>_write`). rdata is combinational from mem_rdata. Writes produce no rvalid.
- Write protect: the memory silently drops writes below 0x200. The arbiter still grants them and asserts `wp_err` for one cycle, one cycle after the grant.
- Address/data are not checked or modified; ADDR_W-bit wrap is the requester's concern.

## Timing
- Reset values: all `*_gnt`, `*_rvalid`, mem_en, mem_write, wp_err = 0; state `OPEN`; lock counter 0; `last` = spr. Combinational outputs go low because state is reset and reqs are qualified.
- Grant is same-cycle, combinational from req and state. The requester must hold req/addr/wdata stable until it sees gnt.
- Read latency: gnt at cycle N → rvalid and valid rdata at N+1. Back-to-back grants give one rdata per cycle.
- Reset asserted mid-burst: rvalid and wp_err clear immediately (async), the lock is dropped, and the in-flight read is lost.
- ld_req rising during `LOCKED`: ld waits until `OPEN`, which is at most `LOCK_MAX` cycles away.
- cpu and spr requesting in the same cycle as a lock release: arbitration uses the `OPEN` rules from the next cycle.

## Test plan
- Reset: hold rst_n=0 with all reqs=1, then release. All gnt/rvalid=0 during reset. First cycle after release: ld_gnt=1.
- Round-robin: cpu_req=spr_req=1 with no lock for 4 cycles. Grants alternate cpu, spr, cpu, spr. Each rvalid follows one cycle later with rdata matching preloaded memory.
- Lock burst: cpu with lock=1 reads 0x300–0x304 while spr_req=1. 5 consecutive cpu_gnt. spr_gnt arrives only in the cycle after cpu_lock drops.
- Watchdog: LOCK_MAX=4, spr holds lock and req continuously with cpu_req=1. spr_gnt for 4 cycles, then cpu_gnt=1 on the next cycle.
- Loader priority and write protect: ld writes 0xAB to 0x050 while cpu_req=1. ld_gnt=1, cpu_gnt=0. wp_err=1 on the next cycle, and reading 0x050 still returns the font byte.
- Idle lock: cpu lock=1 with req=0 for 3 cycles while spr_req=1. No grants and mem_en=0 during that time. spr is granted after the lock drops.

Source files
------------

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares port A of the Chip-8 CPU memory between three requesters: the ROM
// loader (ld), the CPU core (cpu) and the sprite draw unit (spr). One access
// is issued per cycle. Grants are combinational. Read data is the memory's
// registered output and is flagged one cycle after the grant by a
// per-requester rvalid. cpu and spr may hold the port for a burst using their
// lock input. A hold counter forces the port open after LOCK_MAX cycles.
//
// State table
//   state        | meaning
//   ST_OPEN      | normal arbitration: ld first, then cpu/spr round-robin
//   ST_LOCK_CPU  | cpu owns the port; only cpu may be granted
//   ST_LOCK_SPR  | spr owns the port; only spr may be granted
//
// Ports
//   clk_i                 system clock, rising edge
//   rst_n_i               asynchronous active-low reset
//   <r>_req_i             access request (r = ld, cpu, spr)
//   <r>_lock_i            keep ownership after this access (ignored for ld)
//   <r>_write_i           1 = write, 0 = read
//   <r>_addr_i            access address
//   <r>_wdata_i           write data
//   <r>_gnt_o             access accepted this cycle (combinational)
//   <r>_rvalid_o          rdata_o valid for the read granted last cycle
//   rdata_o               shared read data, straight from mem_rdata_i
//   mem_en_o              memory port enable
//   mem_write_o           memory write strobe
//   mem_addr_o            memory address
//   mem_wdata_o           memory write data
//   mem_rdata_i           memory registered read data
//   wp_err_o              one-cycle pulse after a granted write below 0x200
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 8,
    parameter int LOCK_MAX = 16
) (
    input  logic              clk_i,
    input  logic              rst_n_i,

    input  logic              ld_req_i,
    input  logic              ld_lock_i,
    input  logic              ld_write_i,
    input  logic [ADDR_W-1:0] ld_addr_i,
    input  logic [DATA_W-1:0] ld_wdata_i,
    output logic              ld_gnt_o,
    output logic              ld_rvalid_o,

    input  logic              cpu_req_i,
    input  logic              cpu_lock_i,
    input  logic              cpu_write_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    output logic              cpu_gnt_o,
    output logic              cpu_rvalid_o,

    input  logic              spr_req_i,
    input  logic              spr_lock_i,
    input  logic              spr_write_i,
    input  logic [ADDR_W-1:0] spr_addr_i,
    input  logic [DATA_W-1:0] spr_wdata_i,
    output logic              spr_gnt_o,
    output logic              spr_rvalid_o,

    output logic [DATA_W-1:0] rdata_o,

    output logic              mem_en_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,

    output logic              wp_err_o
);

    typedef enum logic [1:0] {
        ST_OPEN     = 2'd0,
        ST_LOCK_CPU = 2'd1,
        ST_LOCK_SPR = 2'd2
    } state_e;

    localparam logic [7:0]        LOCK_MAX_C = 8'(LOCK_MAX);
    localparam logic [ADDR_W-1:0] WP_LIMIT   = ADDR_W'('h200);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  cnt_inc;
    // 1 when spr was the most recent cpu/spr winner, 0 when cpu was
    logic        last_spr_q, last_spr_d;

    logic        ld_gnt, cpu_gnt, spr_gnt;
    logic        ld_rvalid_q, cpu_rvalid_q, spr_rvalid_q;
    logic        ld_rvalid_d, cpu_rvalid_d, spr_rvalid_d;
    logic        wp_err_q, wp_err_d;

    logic        unused_ld_lock;
    assign unused_ld_lock = ld_lock_i;

    assign cnt_inc = cnt_q + 8'd1;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= ST_OPEN;
            cnt_q        <= 8'd0;
            last_spr_q   <= 1'b1;
            ld_rvalid_q  <= 1'b0;
            cpu_rvalid_q <= 1'b0;
            spr_rvalid_q <= 1'b0;
            wp_err_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_spr_q   <= last_spr_d;
            ld_rvalid_q  <= ld_rvalid_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            spr_rvalid_q <= spr_rvalid_d;
            wp_err_q     <= wp_err_d;
        end
    end

    // Next state and raw grants
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_spr_d = last_spr_q;
        ld_gnt     = 1'b0;
        cpu_gnt    = 1'b0;
        spr_gnt    = 1'b0;

        unique case (state_q)
            ST_OPEN: begin
                if (ld_req_i) begin
                    ld_gnt = 1'b1;
                end else if (cpu_req_i && spr_req_i) begin
                    // the requester that did not win most recently goes first
                    cpu_gnt = last_spr_q;
                    spr_gnt = !last_spr_q;
                end else begin
                    cpu_gnt = cpu_req_i;
                    spr_gnt = spr_req_i;
                end

                if (cpu_gnt) begin
                    last_spr_d = 1'b0;
                    if (cpu_lock_i) begin
                        state_d = ST_LOCK_CPU;
                        cnt_d   = 8'd1;
                    end
                end else if (spr_gnt) begin
                    last_spr_d = 1'b1;
                    if (spr_lock_i) begin
                        state_d = ST_LOCK_SPR;
                        cnt_d   = 8'd1;
                    end
                end
            end

            ST_LOCK_CPU: begin
                // idle cycles still count against the hold limit
                cpu_gnt = cpu_req_i;
                cnt_d   = cnt_inc;
                if (!cpu_lock_i || (cnt_inc >= LOCK_MAX_C)) begin
                    state_d    = ST_OPEN;
                    cnt_d      = 8'd0;
                    last_spr_d = 1'b0;
                end
            end

            ST_LOCK_SPR: begin
                spr_gnt = spr_req_i;
                cnt_d   = cnt_inc;
                if (!spr_lock_i || (cnt_inc >= LOCK_MAX_C)) begin
                    state_d    = ST_OPEN;
                    cnt_d      = 8'd0;
                    last_spr_d = 1'b1;
                end
            end

            default: begin
                state_d = ST_OPEN;
                cnt_d   = 8'd0;
            end
        endcase
    end

    // Grants are forced low while reset is held so nothing reaches memory
    assign ld_gnt_o  = ld_gnt  & rst_n_i;
    assign cpu_gnt_o = cpu_gnt & rst_n_i;
    assign spr_gnt_o = spr_gnt & rst_n_i;

    // Memory port mux from the (one-hot) winner
    always_comb begin
        mem_en_o    = 1'b0;
        mem_write_o = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (ld_gnt_o) begin
            mem_en_o    = 1'b1;
            mem_write_o = ld_write_i;
            mem_addr_o  = ld_addr_i;
            mem_wdata_o = ld_wdata_i;
        end else if (cpu_gnt_o) begin
            mem_en_o    = 1'b1;
            mem_write_o = cpu_write_i;
            mem_addr_o  = cpu_addr_i;
            mem_wdata_o = cpu_wdata_i;
        end else if (spr_gnt_o) begin
            mem_en_o    = 1'b1;
            mem_write_o = spr_write_i;
            mem_addr_o  = spr_addr_i;
            mem_wdata_o = spr_wdata_i;
        end
    end

    // Return path and write-protect flag
    always_comb begin
        ld_rvalid_d  = ld_gnt_o  & !ld_write_i;
        cpu_rvalid_d = cpu_gnt_o & !cpu_write_i;
        spr_rvalid_d = spr_gnt_o & !spr_write_i;
        wp_err_d     = mem_en_o & mem_write_o & (mem_addr_o < WP_LIMIT);
    end

    assign ld_rvalid_o  = ld_rvalid_q;
    assign cpu_rvalid_o = cpu_rvalid_q;
    assign spr_rvalid_o = spr_rvalid_q;
    assign wp_err_o     = wp_err_q;
    assign rdata_o      = mem_rdata_i;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    localparam int AW = 12;
    localparam int DW = 8;
    localparam int LM = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // index 0 = ld, 1 = cpu, 2 = spr
    logic          req   [3];
    logic          lock  [3];
    logic          wr    [3];
    logic [AW-1:0] addr  [3];
    logic [DW-1:0] wdata [3];

    logic          ld_gnt, cpu_gnt, spr_gnt;
    logic          ld_rv, cpu_rv, spr_rv;
    logic [DW-1:0] rdata;
    logic          mem_en, mem_write, wp_err;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;

    logic [2:0] gnt, rv;
    assign gnt = {spr_gnt, cpu_gnt, ld_gnt};
    assign rv  = {spr_rv, cpu_rv, ld_rv};

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LOCK_MAX(LM)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .ld_req_i(req[0]), .ld_lock_i(lock[0]), .ld_write_i(wr[0]),
        .ld_addr_i(addr[0]), .ld_wdata_i(wdata[0]),
        .ld_gnt_o(ld_gnt), .ld_rvalid_o(ld_rv),
        .cpu_req_i(req[1]), .cpu_lock_i(lock[1]), .cpu_write_i(wr[1]),
        .cpu_addr_i(addr[1]), .cpu_wdata_i(wdata[1]),
        .cpu_gnt_o(cpu_gnt), .cpu_rvalid_o(cpu_rv),
        .spr_req_i(req[2]), .spr_lock_i(lock[2]), .spr_write_i(wr[2]),
        .spr_addr_i(addr[2]), .spr_wdata_i(wdata[2]),
        .spr_gnt_o(spr_gnt), .spr_rvalid_o(spr_rv),
        .rdata_o(rdata),
        .mem_en_o(mem_en), .mem_write_o(mem_write),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata),
        .wp_err_o(wp_err)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] init_byte(input int a);
        logic [7:0] b;
        b = 8'(a);
        if (a == 'h050) return 8'hF0;
        return b ^ 8'h5A;
    endfunction

    // Memory behind port A: registered read, writes below 0x200 dropped
    logic [DW-1:0] mem [4096];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_write) begin
                if (mem_addr >= 12'h200) mem[mem_addr] <= mem_wdata;
            end else begin
                mem_rdata <= mem[mem_addr];
            end
        end
    end

    // Reference model: owner of the port, cycles it has held it, last winner
    logic [DW-1:0] ref_mem [4096];
    int            m_owner = -1;
    int            m_held  = 0;
    int            m_last  = 2;
    int            m_win   = -1;
    logic [2:0]    e_rv    = '0;
    logic [DW-1:0] e_rdata = '0;
    logic          e_wp    = 1'b0;

    function automatic int pick();
        if (m_owner >= 0) return req[m_owner] ? m_owner : -1;
        if (req[0]) return 0;
        if (req[1] && req[2]) return (m_last == 1) ? 2 : 1;
        if (req[1]) return 1;
        if (req[2]) return 2;
        return -1;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_gnt", gnt, 0);
            chk("rst_rvalid", rv, 0);
            chk("rst_wp_err", wp_err, 0);
            chk("rst_mem_en", mem_en, 0);
            m_owner = -1; m_held = 0; m_last = 2; m_win = -1;
            e_rv = '0; e_wp = 1'b0;
        end else begin
            m_win = pick();
            for (int i = 0; i < 3; i++) chk("cmp_gnt", gnt[i], (m_win == i));
            chk("cmp_mem_en", mem_en, (m_win >= 0));
            if (m_win >= 0) begin
                chk("cmp_mem_write", mem_write, wr[m_win]);
                chk("cmp_mem_addr", mem_addr, addr[m_win]);
                if (wr[m_win]) chk("cmp_mem_wdata", mem_wdata, wdata[m_win]);
            end else begin
                chk("cmp_mem_write_idle", mem_write, 0);
            end
            chk("cmp_rvalid", rv, e_rv);
            if (e_rv != 0) chk("cmp_rdata", rdata, e_rdata);
            chk("cmp_wp_err", wp_err, e_wp);

            e_rv = '0;
            e_wp = 1'b0;
            if (m_win >= 0) begin
                if (!wr[m_win]) begin
                    e_rv[m_win] = 1'b1;
                    e_rdata = ref_mem[addr[m_win]];
                end else if (addr[m_win] < 12'h200) begin
                    e_wp = 1'b1;
                end else begin
                    ref_mem[addr[m_win]] = wdata[m_win];
                end
            end

            if (m_owner < 0) begin
                if (m_win == 1 || m_win == 2) begin
                    m_last = m_win;
                    if (lock[m_win]) begin
                        m_owner = m_win;
                        m_held  = 1;
                    end
                end
            end else begin
                m_held++;
                if (!lock[m_owner] || m_held >= LM) begin
                    m_last  = m_owner;
                    m_owner = -1;
                    m_held  = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_mid();
        @(negedge clk);
        #1;
    endtask

    task automatic set_r(input int i, input logic r, input logic l, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        req[i] = r; lock[i] = l; wr[i] = w; addr[i] = a; wdata[i] = d;
    endtask

    task automatic idle_all();
        for (int i = 0; i < 3; i++) set_r(i, 1'b0, 1'b0, 1'b0, 12'h000, 8'h00);
    endtask

    initial begin
        for (int a = 0; a < 4096; a++) begin
            mem[a]     = init_byte(a);
            ref_mem[a] = init_byte(a);
        end
        set_r(0, 1'b1, 1'b0, 1'b0, 12'h100, 8'h00);
        set_r(1, 1'b1, 1'b0, 1'b0, 12'h210, 8'h00);
        set_r(2, 1'b1, 1'b0, 1'b0, 12'h220, 8'h00);

        // reset with everyone requesting
        at_mid();
        chk("reset_ld_gnt", ld_gnt, 0);
        chk("reset_cpu_gnt", cpu_gnt, 0);
        at_mid();
        tick();
        rst_n = 1'b1;
        at_mid();
        chk("first_ld_gnt", ld_gnt, 1);
        chk("first_cpu_gnt", cpu_gnt, 0);
        tick();
        idle_all();
        at_mid();
        chk("first_ld_rvalid", ld_rv, 1);
        chk("first_ld_rdata", rdata, 8'h5A);

        // round-robin: cpu, spr, cpu, spr
        tick();
        set_r(1, 1'b1, 1'b0, 1'b0, 12'h210, 8'h00);
        set_r(2, 1'b1, 1'b0, 1'b0, 12'h220, 8'h00);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) tick();
            at_mid();
            chk("rr_cpu_gnt", cpu_gnt, (k % 2 == 0));
            chk("rr_spr_gnt", spr_gnt, (k % 2 == 1));
            if (k % 2 == 1) begin
                chk("rr_cpu_rvalid", cpu_rv, 1);
                chk("rr_cpu_rdata", rdata, 8'h4A);
            end else if (k > 0) begin
                chk("rr_spr_rvalid", spr_rv, 1);
                chk("rr_spr_rdata", rdata, 8'h7A);
            end
        end
        tick();
        idle_all();
        at_mid();
        chk("rr_last_spr_rvalid", spr_rv, 1);
        chk("rr_last_spr_rdata", rdata, 8'h7A);

        // locked cpu burst 0x300..0x304 with spr waiting
        tick();
        set_r(1, 1'b1, 1'b1, 1'b0, 12'h300, 8'h00);
        set_r(2, 1'b1, 1'b0, 1'b0, 12'h220, 8'h00);
        for (int k = 0; k < 5; k++) begin
            at_mid();
            chk("burst_cpu_gnt", cpu_gnt, 1);
            chk("burst_spr_gnt", spr_gnt, 0);
            tick();
            if (k < 4) set_r(1, 1'b1, (k != 3), 1'b0, 12'(12'h301 + k), 8'h00);
            else       set_r(1, 1'b0, 1'b0, 1'b0, 12'h000, 8'h00);
        end
        at_mid();
        chk("burst_release_spr_gnt", spr_gnt, 1);
        chk("burst_tail_rdata", rdata, 8'h5E);

        // watchdog: spr holds lock, cpu waits
        tick();
        set_r(2, 1'b1, 1'b1, 1'b0, 12'h240, 8'h00);
        for (int k = 0; k < LM; k++) begin
            at_mid();
            chk("wd_spr_gnt", spr_gnt, 1);
            chk("wd_cpu_gnt", cpu_gnt, 0);
            tick();
            if (k == 0) set_r(1, 1'b1, 1'b0, 1'b0, 12'h210, 8'h00);
        end
        at_mid();
        chk("wd_forced_cpu_gnt", cpu_gnt, 1);
        chk("wd_forced_spr_gnt", spr_gnt, 0);
        tick();
        set_r(1, 1'b0, 1'b0, 1'b0, 12'h000, 8'h00);
        at_mid();
        chk("wd_relock_spr_gnt", spr_gnt, 1);
        tick();
        idle_all();
        at_mid();
        chk("wd_idle_mem_en", mem_en, 0);

        // loader priority and write protect
        tick();
        set_r(0, 1'b1, 1'b0, 1'b1, 12'h050, 8'hAB);
        set_r(1, 1'b1, 1'b0, 1'b0, 12'h210, 8'h00);
        at_mid();
        chk("wp_ld_gnt", ld_gnt, 1);
        chk("wp_cpu_gnt", cpu_gnt, 0);
        tick();
        set_r(0, 1'b0, 1'b0, 1'b0, 12'h000, 8'h00);
        at_mid();
        chk("wp_err_pulse", wp_err, 1);
        chk("wp_cpu_gnt_after", cpu_gnt, 1);
        tick();
        set_r(1, 1'b1, 1'b0, 1'b0, 12'h050, 8'h00);
        at_mid();
        chk("wp_err_single", wp_err, 0);
        tick();
        set_r(1, 1'b0, 1'b0, 1'b0, 12'h000, 8'h00);
        at_mid();
        chk("wp_font_rvalid", cpu_rv, 1);
        chk("wp_font_rdata", rdata, 8'hF0);

        // idle lock: cpu owns the port without requesting
        tick();
        set_r(1, 1'b1, 1'b1, 1'b0, 12'h230, 8'h00);
        at_mid();
        chk("idle_entry_cpu_gnt", cpu_gnt, 1);
        tick();
        set_r(1, 1'b0, 1'b1, 1'b0, 12'h000, 8'h00);
        set_r(2, 1'b1, 1'b0, 1'b0, 12'h220, 8'h00);
        for (int k = 0; k < 3; k++) begin
            at_mid();
            chk("idle_no_gnt", gnt, 0);
            chk("idle_mem_en", mem_en, 0);
            tick();
        end
        lock[1] = 1'b0;
        at_mid();
        chk("idle_drop_spr_gnt", spr_gnt, 0);
        tick();
        at_mid();
        chk("idle_after_spr_gnt", spr_gnt, 1);

        // reset in the middle of a locked read burst
        tick();
        set_r(2, 1'b1, 1'b1, 1'b0, 12'h240, 8'h00);
        at_mid();
        chk("arst_spr_gnt", spr_gnt, 1);
        tick();
        chk("arst_pre_rvalid", spr_rv, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_rvalid_cleared", spr_rv, 0);
        at_mid();
        tick();
        rst_n = 1'b1;
        set_r(1, 1'b1, 1'b0, 1'b0, 12'h210, 8'h00);
        at_mid();
        chk("arst_cpu_first", cpu_gnt, 1);
        chk("arst_spr_blocked", spr_gnt, 0);

        // randomized traffic against the reference model
        for (int c = 0; c < 3000; c++) begin
            tick();
            for (int i = 0; i < 3; i++) begin
                if (!req[i] || m_win == i) begin
                    req[i] = ($urandom_range(0, 99) < ((i == 0) ? 10 : 60));
                    wr[i]  = ($urandom_range(0, 9) < 4);
                    if (wr[i] && $urandom_range(0, 9) < 2) addr[i] = AW'($urandom_range(0, 'h1FF));
                    else                                   addr[i] = AW'($urandom_range('h1F0, 'h27F));
                    wdata[i] = DW'($urandom);
                end
                lock[i] = ($urandom_range(0, 9) < 7);
            end
        end
        tick();
        idle_all();
        repeat (3) at_mid();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
